pkt_store_fifo: RTL

//  Parametrised multi-frame packet store between frame_receiver and downstream consumers.

---
 rtl/pkt_store_pkg.sv | 22 ++
 rtl/pkt_desc_fifo.sv | 52 +++++
 rtl/pkt_store_fifo.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/pkt_store_pkg.sv
// Shared types and defaults for the multi-frame packet store.
// Used by pkt_store_fifo and pkt_desc_fifo.
package pkt_store_pkg;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_RECV = 2'd1,
    W_DROP = 2'd2
  } wstate_e;

  localparam int DATA_W_DEF  = 8;
  localparam int ADDR_W_DEF  = 11;
  localparam int LEN_W_DEF   = 11;
  localparam int DESC_AW_DEF = 4;
  localparam int CNT_W       = 16;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/pkt_desc_fifo.sv
// Synchronous FIFO of committed frame lengths; head entry is visible on dout.
// Full, empty and occupancy count derive from wrap-bit pointers.
module pkt_desc_fifo
  import pkt_store_pkg::*;
#(
  parameter int W  = LEN_W_DEF,
  parameter int AW = DESC_AW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  logic [W-1:0] mem [2**AW];
  logic [AW:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic         do_push, do_pop;

  assign count   = wr_ptr_q - rd_ptr_q;
  assign full    = (count == (AW+1)'(2**AW));
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q[AW-1:0]] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

endmodule

// File: rtl/pkt_store_fifo.sv
// Multi-frame packet store: circular byte RAM, commit/rewind write FSM, valid/ready replay.
// Optional statistics counters are built when PKT_STORE_STATS_EN is defined.
module pkt_store_fifo
  import pkt_store_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int LEN_W   = LEN_W_DEF,
  parameter int DESC_AW = DESC_AW_DEF
) (
  input  logic               iclk,
  input  logic               i_rst_n,
  input  logic               idv,
  input  logic [DATA_W-1:0]  irx_d,
  input  logic               i_error,
  output logic               o_val,
  input  logic               i_rdy,
  output logic [DATA_W-1:0]  o_data,
  output logic               o_sop,
  output logic               o_eop,
  output logic [LEN_W-1:0]   o_len,
  output logic [DESC_AW:0]   o_frames,
  output logic               o_drop,
  output logic [CNT_W-1:0]   o_acc_cnt,
  output logic [CNT_W-1:0]   o_drop_cnt
);

  localparam int DEPTH = 2**ADDR_W;
  localparam int FW    = ((ADDR_W > LEN_W) ? ADDR_W : LEN_W) + 2;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  wstate_e           wstate_q, wstate_d;
  logic [ADDR_W:0]   wr_commit_q, wr_commit_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_W-1:0] fetch_ptr_q, fetch_ptr_d, waddr;
  logic [LEN_W-1:0]  len_q, len_d, fetch_cnt_q, fetch_cnt_d, olen_q, olen_d;
  logic              armed_q, armed_d, drop_q, drop_d;
  logic              out_vld_q, out_vld_d, sop_q, sop_d, eop_q, eop_d;
  logic              we, advance, fetch;
  logic              desc_push, desc_pop, desc_full, desc_empty;
  logic [LEN_W-1:0]  desc_head;
  logic [DESC_AW:0]  desc_count;
  logic [ADDR_W:0]   used;
  logic [FW-1:0]     free;

  assign used = wr_commit_q - rd_ptr_q;
  assign free = FW'(DEPTH) - FW'(used) - FW'(len_q);

  // After reset the tail of an interrupted frame must not look like a new frame,
  // so reception is only armed once idv has been seen low.
  always_comb begin
    wstate_d    = wstate_q;
    len_d       = len_q;
    wr_commit_d = wr_commit_q;
    armed_d     = armed_q | ~idv;
    drop_d      = 1'b0;
    we          = 1'b0;
    waddr       = wr_commit_q[ADDR_W-1:0];
    desc_push   = 1'b0;
    case (wstate_q)
      W_IDLE: begin
        if (idv && armed_q) begin
          if (i_error || used[ADDR_W]) begin
            wstate_d = W_DROP;
            drop_d   = 1'b1;
          end else begin
            we       = 1'b1;
            len_d    = LEN_W'(1);
            wstate_d = W_RECV;
          end
        end
      end
      W_RECV: begin
        waddr = wr_commit_q[ADDR_W-1:0] + ADDR_W'(len_q);
        if (idv) begin
          if (i_error || (free == '0) || (&len_q)) begin
            wstate_d = W_DROP;
            drop_d   = 1'b1;
          end else begin
            we    = 1'b1;
            len_d = len_q + LEN_W'(1);
          end
        end else begin
          wstate_d = W_IDLE;
          if (!i_error && !desc_full) begin
            desc_push   = 1'b1;
            wr_commit_d = wr_commit_q + (ADDR_W+1)'(len_q);
          end else begin
            drop_d = 1'b1;
          end
        end
      end
      W_DROP: begin
        if (!idv) wstate_d = W_IDLE;
      end
      default: wstate_d = W_IDLE;
    endcase
  end

  // The RAM read register is the output data stage; it only advances when the
  // consumer has taken the current beat, so no skid buffer is needed.
  assign advance  = !out_vld_q || i_rdy;
  assign fetch    = advance && !desc_empty && (fetch_cnt_q != desc_head);
  assign desc_pop = out_vld_q && i_rdy && eop_q;

  always_comb begin
    out_vld_d   = out_vld_q;
    sop_d       = sop_q;
    eop_d       = eop_q;
    olen_d      = olen_q;
    fetch_ptr_d = fetch_ptr_q;
    fetch_cnt_d = fetch_cnt_q;
    rd_ptr_d    = rd_ptr_q;
    if (out_vld_q && i_rdy) rd_ptr_d = rd_ptr_q + (ADDR_W+1)'(1);
    if (advance) begin
      out_vld_d = fetch;
      if (fetch) begin
        sop_d       = (fetch_cnt_q == '0);
        eop_d       = ((fetch_cnt_q + LEN_W'(1)) == desc_head);
        olen_d      = desc_head;
        fetch_ptr_d = fetch_ptr_q + ADDR_W'(1);
        fetch_cnt_d = fetch_cnt_q + LEN_W'(1);
      end
    end
    if (desc_pop) fetch_cnt_d = '0;
  end

  always_ff @(posedge iclk) begin
    if (we)    mem[waddr] <= irx_d;
    if (fetch) rdata_q    <= mem[fetch_ptr_q];
  end

  always_ff @(posedge iclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wstate_q    <= W_IDLE;
      len_q       <= '0;
      wr_commit_q <= '0;
      armed_q     <= 1'b0;
      drop_q      <= 1'b0;
      rd_ptr_q    <= '0;
      fetch_ptr_q <= '0;
      fetch_cnt_q <= '0;
      out_vld_q   <= 1'b0;
      sop_q       <= 1'b0;
      eop_q       <= 1'b0;
      olen_q      <= '0;
    end else begin
      wstate_q    <= wstate_d;
      len_q       <= len_d;
      wr_commit_q <= wr_commit_d;
      armed_q     <= armed_d;
      drop_q      <= drop_d;
      rd_ptr_q    <= rd_ptr_d;
      fetch_ptr_q <= fetch_ptr_d;
      fetch_cnt_q <= fetch_cnt_d;
      out_vld_q   <= out_vld_d;
      sop_q       <= sop_d;
      eop_q       <= eop_d;
      olen_q      <= olen_d;
    end
  end

  pkt_desc_fifo #(.W(LEN_W), .AW(DESC_AW)) u_desc (
    .clk   (iclk),
    .rst_n (i_rst_n),
    .push  (desc_push),
    .din   (len_q),
    .pop   (desc_pop),
    .dout  (desc_head),
    .full  (desc_full),
    .empty (desc_empty),
    .count (desc_count)
  );

  assign o_val    = out_vld_q;
  assign o_data   = out_vld_q ? rdata_q : '0;
  assign o_sop    = out_vld_q & sop_q;
  assign o_eop    = out_vld_q & eop_q;
  assign o_len    = out_vld_q ? olen_q : '0;
  assign o_frames = desc_count;
  assign o_drop   = drop_q;

`ifdef PKT_STORE_STATS_EN
  logic [CNT_W-1:0] acc_cnt_q, acc_cnt_d, drop_cnt_q, drop_cnt_d;

  always_comb begin
    acc_cnt_d  = desc_push ? sat_inc(acc_cnt_q) : acc_cnt_q;
    drop_cnt_d = drop_q ? sat_inc(drop_cnt_q) : drop_cnt_q;
  end

  always_ff @(posedge iclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      acc_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      acc_cnt_q  <= acc_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign o_acc_cnt  = acc_cnt_q;
  assign o_drop_cnt = drop_cnt_q;
`else
  assign o_acc_cnt  = '0;
  assign o_drop_cnt = '0;
`endif

endmodule
